// File: rtl/tinymem_wbuf_pkg.sv
// Shared definitions for the tinymem write buffer.
//   mem_access_size_t : access size encoding shared by the core and memory ports
//   WBUF_DEPTH        : default number of buffered stores
//   wbuf_entry_t      : one buffered store {addr, data, size}
package tinymem_wbuf_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_access_size_t;

  localparam int WBUF_DEPTH = 4;

  typedef struct packed {
    logic [31:0]      addr;
    logic [31:0]      data;
    mem_access_size_t size;
  } wbuf_entry_t;

endpackage

// File: rtl/tinymem_wbuf_fifo.sv
// Circular store FIFO for the write buffer.
//   clk, reset_n  : clock, async active-low reset (clears pointers and count)
//   i_enq         : write i_enq_entry at the tail on this edge
//   i_deq         : retire the head entry on this edge
//   o_head_entry  : oldest entry (valid when o_count != 0)
//   o_count       : number of buffered entries, 0..DEPTH
//   o_age_entry   : all slots reordered by age, index 0 = oldest
//   o_age_vld     : which age slots hold a live entry
module tinymem_wbuf_fifo
  import tinymem_wbuf_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_enq,
  input  wbuf_entry_t               i_enq_entry,
  input  logic                      i_deq,
  output wbuf_entry_t               o_head_entry,
  output logic [$clog2(DEPTH):0]    o_count,
  output wbuf_entry_t [DEPTH-1:0]   o_age_entry,
  output logic [DEPTH-1:0]          o_age_vld
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wbuf_entry_t     r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  // Storage needs no reset: nothing reads a slot outside the live window.
  always_ff @(posedge clk) begin
    if (i_enq) r_mem[r_tail] <= i_enq_entry;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_enq) r_tail <= r_tail + PW'(1);
      if (i_deq) r_head <= r_head + PW'(1);
      case ({i_enq, i_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_entry = r_mem[r_head];
  assign o_count      = r_count;

  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    logic [PW-1:0] w_idx;
    assign w_idx          = r_head + PW'(k);
    assign o_age_entry[k] = r_mem[w_idx];
    assign o_age_vld[k]   = (CW'(k) < r_count);
  end

endmodule

// File: rtl/tinymem_wbuf.sv
// Write buffer between a core and a single-ported memory.
// Stores are queued and drained when the memory port is free; loads go
// straight through, are forwarded from the newest matching buffered word,
// or stall until a partially overlapping store has drained.
//   clk, reset_n          : clock, async active-low reset
//   cpu_rd_*              : core load request (addr/size) and returned data
//   cpu_wr_*              : core store request
//   cpu_stall             : core must hold its request this cycle
//   mem_rd_*, mem_rd_data : downstream load
//   mem_wr_*              : downstream store (drain of the head entry)
module tinymem_wbuf
  import tinymem_wbuf_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cpu_rd_addr,
  input  logic [1:0]  cpu_rd_size,
  output logic [31:0] cpu_rd_data,
  input  logic        cpu_rd_enable,
  input  logic [31:0] cpu_wr_addr,
  input  logic [31:0] cpu_wr_data,
  input  logic [1:0]  cpu_wr_size,
  input  logic        cpu_wr_enable,
  output logic        cpu_stall,
  output logic [31:0] mem_rd_addr,
  output logic [1:0]  mem_rd_size,
  input  logic [31:0] mem_rd_data,
  output logic        mem_rd_enable,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic [1:0]  mem_wr_size,
  output logic        mem_wr_enable
);

  localparam int CW = $clog2(DEPTH) + 1;

  wbuf_entry_t               w_head;
  wbuf_entry_t               w_enq_entry;
  wbuf_entry_t [DEPTH-1:0]   w_age;
  logic [DEPTH-1:0]          w_age_vld;
  logic [CW-1:0]             w_count;
  logic                      w_ovl, w_fwd, w_hazard, w_drain, w_full, w_enq;
  logic [31:0]               w_sel_data;
  mem_access_size_t          w_sel_size;
  logic [1:0]                w_unused_lo;

  // Walk oldest to newest so the last match wins (newest store).
  // Only entries already in the FIFO are scanned; this cycle's store is not.
  always_comb begin
    w_ovl       = 1'b0;
    w_sel_data  = '0;
    w_sel_size  = SIZE_BYTE;
    w_unused_lo = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_unused_lo = w_unused_lo ^ w_age[k].addr[1:0];
      if (w_age_vld[k] && (w_age[k].addr[31:2] == cpu_rd_addr[31:2])) begin
        w_ovl      = 1'b1;
        w_sel_data = w_age[k].data;
        w_sel_size = w_age[k].size;
      end
    end
  end

  // Only an aligned word load fully covered by a word store can be forwarded.
  assign w_fwd    = cpu_rd_enable && w_ovl && (w_sel_size == SIZE_WORD) &&
                    (mem_access_size_t'(cpu_rd_size) == SIZE_WORD) &&
                    (cpu_rd_addr[1:0] == 2'b00);
  assign w_hazard = cpu_rd_enable && w_ovl && !w_fwd;
  // A hazard frees the port for a drain, which is how the stall resolves.
  assign w_drain  = (w_count != '0) && (!cpu_rd_enable || w_hazard);
  assign w_full   = (w_count == CW'(DEPTH));
  assign cpu_stall = w_hazard || (cpu_wr_enable && w_full && !w_drain);
  assign w_enq    = cpu_wr_enable && !cpu_stall;

  assign w_enq_entry = '{addr: cpu_wr_addr, data: cpu_wr_data,
                         size: mem_access_size_t'(cpu_wr_size)};

  tinymem_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_enq        (w_enq),
    .i_enq_entry  (w_enq_entry),
    .i_deq        (w_drain),
    .o_head_entry (w_head),
    .o_count      (w_count),
    .o_age_entry  (w_age),
    .o_age_vld    (w_age_vld)
  );

  assign mem_rd_addr   = cpu_rd_addr;
  assign mem_rd_size   = cpu_rd_size;
  // Held low while in reset even if the core is still requesting a load.
  assign mem_rd_enable = reset_n && cpu_rd_enable && !cpu_stall;
  assign cpu_rd_data   = w_fwd ? w_sel_data : mem_rd_data;

  assign mem_wr_enable = w_drain;
  assign mem_wr_addr   = w_drain ? w_head.addr : '0;
  assign mem_wr_data   = w_drain ? w_head.data : '0;
  assign mem_wr_size   = w_drain ? w_head.size : 2'b00;

endmodule

// File: tb/tb_tinymem_wbuf.sv
module tb_tinymem_wbuf;
  import tinymem_wbuf_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_W = 2'd2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cpu_rd_addr, cpu_rd_data, cpu_wr_addr, cpu_wr_data;
  logic [1:0]  cpu_rd_size, cpu_wr_size;
  logic        cpu_rd_enable, cpu_wr_enable, cpu_stall;
  logic [31:0] mem_rd_addr, mem_rd_data, mem_wr_addr, mem_wr_data;
  logic [1:0]  mem_rd_size, mem_wr_size;
  logic        mem_rd_enable, mem_wr_enable;

  always #5 clk = ~clk;

  tinymem_wbuf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_rd_addr(cpu_rd_addr), .cpu_rd_size(cpu_rd_size), .cpu_rd_data(cpu_rd_data),
    .cpu_rd_enable(cpu_rd_enable),
    .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data), .cpu_wr_size(cpu_wr_size),
    .cpu_wr_enable(cpu_wr_enable), .cpu_stall(cpu_stall),
    .mem_rd_addr(mem_rd_addr), .mem_rd_size(mem_rd_size), .mem_rd_data(mem_rd_data),
    .mem_rd_enable(mem_rd_enable),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_size(mem_wr_size),
    .mem_wr_enable(mem_wr_enable)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: an ordered list of pending stores, oldest first.
  wbuf_entry_t q[$];
  logic        e_stall, e_drain, e_enq, e_mrd;
  logic [31:0] e_rd_data;
  wbuf_entry_t e_wr;
  logic        s_stall, s_mrd, s_wen;
  logic [31:0] s_rdata, s_waddr, s_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    logic        ovl, fwd, hz;
    wbuf_entry_t sel;
    ovl = 1'b0;
    sel = '0;
    foreach (q[i])
      if (q[i].addr[31:2] == cpu_rd_addr[31:2]) begin
        ovl = 1'b1;
        sel = q[i];
      end
    fwd = cpu_rd_enable && ovl && (sel.size == SIZE_WORD) && (cpu_rd_size == SZ_W) &&
          (cpu_rd_addr[1:0] == 2'b00);
    hz  = cpu_rd_enable && ovl && !fwd;
    e_drain   = (q.size() > 0) && (!cpu_rd_enable || hz);
    e_stall   = hz || (cpu_wr_enable && (q.size() == DEPTH) && !e_drain);
    e_enq     = cpu_wr_enable && !e_stall;
    e_mrd     = cpu_rd_enable && !e_stall;
    e_rd_data = fwd ? sel.data : mem_rd_data;
    e_wr      = e_drain ? q[0] : '0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step(input string tag);
    wbuf_entry_t ent;
    @(negedge clk);
    model_eval();
    chk({tag, ".cnt"},   32'(dut.w_count), 32'(q.size()));
    chk({tag, ".stall"}, 32'(cpu_stall), 32'(e_stall));
    chk({tag, ".mrd"},   32'(mem_rd_enable), 32'(e_mrd));
    chk({tag, ".raddr"}, mem_rd_addr, cpu_rd_addr);
    chk({tag, ".rdata"}, cpu_rd_data, e_rd_data);
    chk({tag, ".wen"},   32'(mem_wr_enable), 32'(e_drain));
    chk({tag, ".waddr"}, mem_wr_addr, e_wr.addr);
    chk({tag, ".wdata"}, mem_wr_data, e_wr.data);
    chk({tag, ".wsize"}, 32'(mem_wr_size), 32'(e_wr.size));
    s_stall = cpu_stall; s_mrd = mem_rd_enable; s_rdata = cpu_rd_data;
    s_wen = mem_wr_enable; s_waddr = mem_wr_addr; s_wdata = mem_wr_data;
    ent = '{addr: cpu_wr_addr, data: cpu_wr_data, size: mem_access_size_t'(cpu_wr_size)};
    @(posedge clk);
    if (e_drain) void'(q.pop_front());
    if (e_enq) q.push_back(ent);
    #1;
  endtask

  task automatic idle();
    cpu_rd_enable = 1'b0; cpu_rd_addr = '0; cpu_rd_size = SZ_W;
    cpu_wr_enable = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0; cpu_wr_size = SZ_W;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    cpu_wr_enable = 1'b1; cpu_wr_addr = a; cpu_wr_data = d; cpu_wr_size = sz;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz);
    cpu_rd_enable = 1'b1; cpu_rd_addr = a; cpu_rd_size = sz;
  endtask

  initial begin
    idle();
    mem_rd_data = 32'h0;
    reset_n = 1'b0;
    load(32'h40, SZ_W);
    #2;
    chk("rst.cnt",   32'(dut.w_count), 32'd0);
    chk("rst.wen",   32'(mem_wr_enable), 32'd0);
    chk("rst.mrd",   32'(mem_rd_enable), 32'd0);
    chk("rst.stall", 32'(cpu_stall), 32'd0);
    chk("rst.waddr", mem_wr_addr, 32'd0);
    chk("rst.wdata", mem_wr_data, 32'd0);
    idle();
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Single store, no loads: drains on the following cycle.
    store(32'h100, 32'hDEADBEEF, SZ_W); step("s1a");
    idle(); step("s1b");
    chk("st1.wen",   32'(s_wen), 32'd1);
    chk("st1.waddr", s_waddr, 32'h100);
    chk("st1.wdata", s_wdata, 32'hDEADBEEF);
    step("s1c");
    chk("st1.cnt", 32'(dut.w_count), 32'd0);

    // Fill while a non-overlapping load holds the port; fifth store stalls.
    load(32'h800, SZ_W);
    for (int i = 0; i < 4; i++) begin
      store(32'h400 + 32'(4 * i), 32'h10 + 32'(i), SZ_W); step("s2fill");
    end
    store(32'h410, 32'h14, SZ_W); step("s2full");
    chk("full.stall", 32'(s_stall), 32'd1);
    cpu_rd_enable = 1'b0; step("s2drain");
    chk("full.accept", 32'(s_stall), 32'd0);
    chk("full.wen",    32'(s_wen), 32'd1);
    chk("full.waddr",  s_waddr, 32'h400);
    chk("full.cnt",    32'(dut.w_count), 32'd4);
    idle();
    repeat (5) step("s2empty");

    // Word store then aligned word load: forwarded, no stall.
    store(32'h200, 32'h12345678, SZ_W); step("s3a");
    idle(); load(32'h200, SZ_W); mem_rd_data = 32'hCAFE0000; step("s3b");
    chk("fwd.data",  s_rdata, 32'h12345678);
    chk("fwd.stall", 32'(s_stall), 32'd0);
    chk("fwd.mrd",   32'(s_mrd), 32'd1);
    step("s3c");
    idle(); repeat (2) step("s3d");

    // Byte store then word load: stalls until drained, then reads memory.
    store(32'h201, 32'hAB, SZ_B); step("s4a");
    idle(); load(32'h200, SZ_W); mem_rd_data = 32'h55667788; step("s4b");
    chk("haz.stall", 32'(s_stall), 32'd1);
    chk("haz.wen",   32'(s_wen), 32'd1);
    step("s4c");
    chk("haz.done",  32'(s_stall), 32'd0);
    chk("haz.mrd",   32'(s_mrd), 32'd1);
    chk("haz.data",  s_rdata, 32'h55667788);
    idle(); step("s4d");

    // Two stores to one word: newest one is forwarded.
    load(32'h900, SZ_W);
    store(32'h300, 32'd1, SZ_W); step("s5a");
    store(32'h300, 32'd2, SZ_W); step("s5b");
    cpu_wr_enable = 1'b0; load(32'h300, SZ_W); step("s5c");
    chk("newest.data", s_rdata, 32'd2);
    idle(); repeat (3) step("s5d");

    // Randomized traffic over a few nearby words.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] lo;
      idle();
      mem_rd_data = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        lo = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
        load(32'h500 + 32'(4 * $urandom_range(0, 2)) + lo, 2'($urandom_range(0, 2)));
      end
      if ($urandom_range(0, 9) < 6) begin
        lo = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
        store(32'h500 + 32'(4 * $urandom_range(0, 2)) + lo, $urandom,
              2'($urandom_range(0, 2)));
      end
      step("rnd");
    end
    idle(); repeat (6) step("rnd_flush");

    // Asynchronous reset with three buffered stores.
    load(32'h900, SZ_W);
    for (int i = 0; i < 3; i++) begin
      store(32'h600 + 32'(4 * i), 32'hA0 + 32'(i), SZ_W); step("s6fill");
    end
    cpu_wr_enable = 1'b0;
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("arst.cnt",   32'(dut.w_count), 32'd0);
    chk("arst.wen",   32'(mem_wr_enable), 32'd0);
    chk("arst.mrd",   32'(mem_rd_enable), 32'd0);
    chk("arst.stall", 32'(cpu_stall), 32'd0);
    chk("arst.waddr", mem_wr_addr, 32'd0);
    chk("arst.wdata", mem_wr_data, 32'd0);
    q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle();
    for (int i = 0; i < 4; i++) begin
      step("s6post");
      chk("arst.nowr", 32'(s_wen), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tinymem_wbuf.md
TINYMEM_WBUF -- requirements
Module: tinymem_wbuf

Interface
REQ-001 Parameter: DEPTH, default 4, number of write-buffer entries (power of two, >=2).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cpu  tinymemif.slave  --  upstream port from the core (rd_addr/rd_size/rd_data, wr_addr/wr_data/wr_size/wr_enable).
REQ-005 cpu_rd_enable  input  1  core is performing a load this cycle.
REQ-006 cpu_stall  output  1  core must hold its current request and retry next cycle.
REQ-007 mem  tinymemif.master  --  downstream port to the single-ported memory.
REQ-008 mem_rd_enable  output  1  downstream read in progress this cycle.

Function
REQ-009 The block SHALL hold a circular FIFO of DEPTH entries {addr[31:0], data[31:0], size}, with head/tail pointers and a count of width $clog2(DEPTH)+1.
REQ-010 The downstream port SHALL carry at most one access per cycle: a read when mem_rd_enable=1, a write when mem.wr_enable=1, never both.
REQ-011 Loads SHALL take priority: mem.rd_addr=cpu.rd_addr, mem.rd_size=cpu.rd_size, mem_rd_enable=cpu_rd_enable && !cpu_stall.
REQ-012 Drain SHALL occur when count>0 && (!cpu_rd_enable || hazard); it drives mem.wr_* from the head entry, sets mem.wr_enable=1 and advances the head at the clock edge.
REQ-013 Overlap SHALL mean an entry's addr[31:2] equals cpu.rd_addr[31:2]; on multiple overlaps the newest (closest to the tail) is selected.
REQ-014 Forward SHALL occur when cpu_rd_enable, the selected overlap entry and the load are both word size, and cpu.rd_addr[1:0]=0; cpu.rd_data then equals the entry data, and otherwise equals mem.rd_data.
REQ-015 Hazard SHALL mean cpu_rd_enable && overlap && !forward.
REQ-016 Enqueue SHALL occur when cpu.wr_enable && !cpu_stall; the new entry is written at the tail at the clock edge.
REQ-017 cpu_stall SHALL equal hazard || (cpu.wr_enable && count==DEPTH && !drain).
REQ-018 When the FIFO is full, enqueue and drain in the same cycle SHALL be allowed; count is then unchanged.
REQ-019 Overlap and forward checks SHALL see only entries present before this cycle's enqueue; a same-cycle store is not visible to a same-cycle load.
REQ-020 Pointers SHALL wrap modulo DEPTH.
REQ-021 Count SHALL change by +1 on enqueue only, -1 on drain only, and 0 on both or neither.
REQ-022 When count==0 and no load, all mem.wr_* outputs SHALL be 0.
REQ-023 Latency SHALL be: stores retire to memory at least 1 cycle after acceptance; loads and forwards are combinational (0 cycles).

Reset
REQ-024 reset_n low SHALL asynchronously clear head, tail and count to 0, discarding buffered stores.
REQ-025 During reset, the outputs SHALL be: mem.wr_enable=0, mem_rd_enable=0, cpu_stall=0, mem.wr_addr/wr_data=0.
REQ-026 Reset asserted mid-drain SHALL abort that write with no partial-state retention.

Structure
REQ-027 The shared definitions package SHALL hold the mem_access_size_t encodings, DEPTH default, and the wbuf entry struct typedef.
REQ-028 The FIFO storage/pointer logic SHALL be one sub-module, tinymem_wbuf_fifo; hazard, forward and arbitration logic stay in the top module.

Verification
REQ-029 Store 0x100=0xDEADBEEF (word), no loads: mem.wr_enable=1 on the next cycle with addr 0x100 and data 0xDEADBEEF, after which count is 0.
REQ-030 Five back-to-back word stores while cpu_rd_enable=1 to 0x400 (DEPTH=4): the fifth store sees cpu_stall=1, drain starts, and the fifth store is accepted once the entry frees.
REQ-031 Word store 0x200=0x12345678, then word load 0x200 the next cycle with the load held: cpu.rd_data=0x12345678, cpu_stall=0, and mem_rd_enable=1.
REQ-032 Byte store 0x201=0xAB, then word load 0x200: cpu_stall=1 until the entry drains, then the load completes from memory.
REQ-033 Two stores 0x300=1 and 0x300=2, then word load 0x300: forwarded data is 2, the newest entry.
REQ-034 Fill three entries, pulse reset_n low asynchronously mid-cycle: count is 0 immediately, and no further mem.wr_enable occurs.
